// File: rtl/ifetch_ctrl.sv
// Fetch control around the PC register: issues bus requests and queues returned words for decode.
// Latency: zero-latency response is pushed the same cycle and visible at the queue head next cycle.
// Backpressure: out_ready low fills the 2-entry queue; fetch stops issuing once it holds 2 entries.
module ifetch_ctrl #(
    parameter logic [63:0] RESET_ADDR = 64'h0000_0000,
    parameter int          QDEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pc,
    output logic [63:0] pc_next,
    output logic        pc_stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_ok,
    input  logic [31:0] iresp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_misalign
);

    localparam logic [1:0] FULL = QDEPTH[1:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2,
        HALT = 2'd3
    } state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        misalign;
    } entry_t;

    state_t      state_q;
    state_t      state_d;
    logic [63:0] addr_q;
    logic [1:0]  count_q;
    entry_t      q0;
    entry_t      q1;

    logic        push;
    logic        pop;
    logic        ld_addr;
    entry_t      push_entry;

    // Next-state, bus handshake, PC control and queue push decision.
    always_comb begin
        state_d    = state_q;
        ireq_valid = 1'b0;
        ireq_addr  = addr_q;
        pc_next    = pc + 64'd4;
        pc_stall   = 1'b1;
        push       = 1'b0;
        push_entry = '0;
        ld_addr    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (count_q < FULL) begin
                    if (pc[1:0] == 2'b00) begin
                        ireq_valid = 1'b1;
                        ireq_addr  = pc;
                        if (iresp_ok) begin
                            push       = 1'b1;
                            push_entry = '{pc: pc, instr: iresp_data, misalign: 1'b0};
                        end else begin
                            ld_addr = 1'b1;
                            state_d = WAIT;
                        end
                    end else begin
                        // Misaligned PC: hand decode a marker instead of touching the bus.
                        push       = 1'b1;
                        push_entry = '{pc: pc, instr: 32'h0, misalign: 1'b1};
                        state_d    = HALT;
                    end
                end
            end
            WAIT: begin
                ireq_valid = 1'b1;
                if (iresp_ok) begin
                    push       = 1'b1;
                    push_entry = '{pc: addr_q, instr: iresp_data, misalign: 1'b0};
                    state_d    = IDLE;
                end
            end
            DROP: begin
                // Keep the stale request stable until the bus answers, then throw it away.
                ireq_valid = 1'b1;
                if (iresp_ok) begin
                    state_d = IDLE;
                end
            end
            HALT: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (push && !push_entry.misalign) begin
            pc_stall = 1'b0;
        end

        // A redirect wins over everything; a request left hanging must be drained in DROP.
        if (redirect) begin
            pc_next  = redirect_pc;
            pc_stall = 1'b0;
            push     = 1'b0;
            state_d  = (ireq_valid && !iresp_ok) ? DROP : IDLE;
        end

        if (rst) begin
            ireq_valid = 1'b0;
            pc_stall   = 1'b1;
            push       = 1'b0;
        end
    end

    assign out_valid    = (count_q != 2'd0) && !rst;
    assign pop          = out_valid && out_ready && !redirect;
    assign out_pc       = q0.pc;
    assign out_instr    = q0.instr;
    assign out_misalign = q0.misalign;

    // FSM state and held request address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= RESET_ADDR;
        end else begin
            state_q <= state_d;
            if (ld_addr) begin
                addr_q <= pc;
            end
        end
    end

    // Two-entry shift queue: q0 is always the head, q1 the tail when two are held.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            q0      <= '0;
            q1      <= '0;
        end else if (redirect) begin
            count_q <= 2'd0;
        end else begin
            unique case ({push, pop})
                2'b11: begin
                    if (count_q == 2'd2) begin
                        q0 <= q1;
                        q1 <= push_entry;
                    end else begin
                        q0 <= push_entry;
                    end
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        q0 <= push_entry;
                    end else begin
                        q1 <= push_entry;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    q0      <= q1;
                    count_q <= count_q - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Randomized bench for ifetch_ctrl with a transaction-level fetch model and a PC register model.
// Latency: responses are returned after a per-request random number of cycles.
// Backpressure: out_ready is randomized per phase.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] pc;
    logic [63:0] pc_next;
    logic        pc_stall;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_ok;
    logic [31:0] iresp_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_misalign;

    always #5 clk = ~clk;

    ifetch_ctrl #(.RESET_ADDR(64'h0), .QDEPTH(2)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_next(pc_next), .pc_stall(pc_stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_ok(iresp_ok), .iresp_data(iresp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_instr(out_instr), .out_misalign(out_misalign)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        mis;
    } ent_t;

    // Reference model: what decode should see, plus the one outstanding bus transaction.
    ent_t        mq[$];
    bit          busy;
    bit          discard;
    bit          halted;
    logic [63:0] busy_addr;

    int n_vec = 0;
    int n_err = 0;

    int          lat_min, lat_max, rdy_pct, redir_pct;
    bit          halt_escape, use_fixed, lat_armed;
    int          lat_cnt;
    logic [31:0] fixed_data;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pick_target();
        int sel;
        sel = int'($urandom_range(0, 31));
        if (sel == 0) return 64'hFFFF_FFFF_FFFF_FFF8;
        if (sel < 5)  return 64'h8000_0002 + 64'(4 * $urandom_range(0, 63));
        return 64'h8000_0000 + 64'(4 * $urandom_range(0, 1023));
    endfunction

    task automatic do_reset(input int n);
        rst       = 1'b1;
        redirect  = 1'b0;
        iresp_ok  = 1'b0;
        out_ready = 1'b1;
        repeat (n) begin
            @(negedge clk);
            check("rst_ireq_valid", ireq_valid, 64'd0);
            check("rst_out_valid", out_valid, 64'd0);
            check("rst_pc_stall", pc_stall, 64'd1);
            @(posedge clk);
            #1;
        end
        rst       = 1'b0;
        mq.delete();
        busy      = 1'b0;
        discard   = 1'b0;
        halted    = 1'b0;
        lat_armed = 1'b0;
        pc        = 64'h8000_0000;
    endtask

    task automatic run_cycle();
        bit          e_req, fetched, mis_push, e_stall;
        logic [63:0] e_addr, e_next;
        ent_t        hd;

        if (busy) begin
            e_req  = 1'b1;
            e_addr = busy_addr;
        end else if (!halted && mq.size() < 2 && pc[1:0] == 2'b00) begin
            e_req  = 1'b1;
            e_addr = pc;
        end else begin
            e_req  = 1'b0;
            e_addr = '0;
        end
        mis_push = !busy && !halted && mq.size() < 2 && pc[1:0] != 2'b00;

        redirect    = (int'($urandom_range(0, 99)) < redir_pct) ||
                      (halted && halt_escape && $urandom_range(0, 3) == 0);
        redirect_pc = pick_target();
        out_ready   = int'($urandom_range(0, 99)) < rdy_pct;
        iresp_data  = use_fixed ? fixed_data : $urandom;
        if (e_req) begin
            if (!lat_armed) begin
                lat_cnt   = int'($urandom_range(lat_min, lat_max));
                lat_armed = 1'b1;
            end
            iresp_ok = (lat_cnt == 0);
            if (lat_cnt > 0) lat_cnt--;
        end else begin
            iresp_ok = 1'b0;
        end

        fetched = e_req && iresp_ok && !discard && !redirect;
        e_stall = !(redirect || fetched);
        e_next  = redirect ? redirect_pc : pc + 64'd4;

        @(negedge clk);
        check("ireq_valid", ireq_valid, e_req);
        if (e_req) check("ireq_addr", ireq_addr, e_addr);
        check("pc_stall", pc_stall, e_stall);
        if (!e_stall) check("pc_next", pc_next, e_next);
        check("out_valid", out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            hd = mq[0];
            check("out_pc", out_pc, hd.pc);
            check("out_instr", out_instr, hd.instr);
            check("out_misalign", out_misalign, hd.mis);
        end

        @(posedge clk);
        #1;
        if (redirect) begin
            mq.delete();
            busy      = e_req && !iresp_ok;
            discard   = busy;
            busy_addr = e_addr;
            halted    = 1'b0;
        end else begin
            if (mq.size() != 0 && out_ready) void'(mq.pop_front());
            if (fetched) mq.push_back('{e_addr, iresp_data, 1'b0});
            if (mis_push) begin
                mq.push_back('{pc, 32'h0, 1'b1});
                halted = 1'b1;
            end
            if (e_req) begin
                busy      = !iresp_ok;
                busy_addr = e_addr;
                if (iresp_ok) discard = 1'b0;
            end
        end
        if (iresp_ok) lat_armed = 1'b0;
        if (!e_stall) pc = e_next;
    endtask

    task automatic knobs(input int lmin, input int lmax, input int rdy, input int rdr, input bit esc);
        lat_min     = lmin;
        lat_max     = lmax;
        rdy_pct     = rdy;
        redir_pct   = rdr;
        halt_escape = esc;
    endtask

    initial begin
        pc          = 64'h8000_0000;
        redirect_pc = '0;
        iresp_data  = '0;
        use_fixed   = 1'b1;
        fixed_data  = 32'h0000_0013;
        knobs(0, 0, 100, 0, 1'b0);
        do_reset(2);

        // Zero-latency streaming: one instruction per cycle.
        repeat (20) run_cycle();
        // Fixed 3-cycle response latency.
        knobs(2, 2, 100, 0, 1'b0);
        repeat (20) run_cycle();
        // Decode stalled, then released: queue fills to 2 and drains in order.
        use_fixed = 1'b0;
        knobs(0, 0, 0, 0, 1'b0);
        repeat (8) run_cycle();
        knobs(0, 0, 100, 0, 1'b0);
        repeat (8) run_cycle();
        // Misaligned PC: marker emitted, PC held until a redirect arrives.
        do_reset(1);
        pc = 64'h8000_0002;
        repeat (8) run_cycle();
        knobs(0, 1, 100, 0, 1'b1);
        repeat (12) run_cycle();
        // Random traffic with redirects, latencies and backpressure.
        knobs(0, 3, 70, 6, 1'b1);
        repeat (3000) run_cycle();
        do_reset(1);
        knobs(0, 2, 40, 15, 1'b1);
        repeat (3000) run_cycle();
        knobs(0, 0, 95, 3, 1'b1);
        repeat (2000) run_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Fetch control stage wrapped around the PC register.
- Consumes the current fetch PC and computes the next PC and the stall for the PC register.
- Drives the instruction-bus request handshake and buffers returned instructions in a 2-entry output queue for decode.
- Handles redirects (branch/exception) by flushing queued instructions and discarding any in-flight response.

Parameters:
- RESET_ADDR, 64'h0000_0000, reset value of addr_q (diagnostic only; the PC register owns the reset vector)
- QDEPTH, 2, output queue depth (fixed at 2; other values unsupported)

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous active-high reset
- pc  in  64  current fetch PC from the PC register
- pc_next  out  64  next PC to the PC register (loaded when pc_stall=0)
- pc_stall  out  1  1 = PC register holds its value
- redirect  in  1  flush and redirect, one-cycle pulse, highest priority
- redirect_pc  in  64  redirect target
- ireq_valid  out  1  instruction-bus request
- ireq_addr  out  64  request address
- iresp_ok  in  1  response valid; may assert in the same cycle as the request
- iresp_data  in  32  instruction word, valid when iresp_ok=1
- out_valid  out  1  queue head valid to decode
- out_ready  in  1  decode accepts head
- out_pc  out  64  PC of head
- out_instr  out  32  instruction of head (0 when out_misalign=1)
- out_misalign  out  1  head is a misaligned-fetch marker

Behaviour:
- Reset (synchronous): state=IDLE, count=0, addr_q=RESET_ADDR, all queue entries invalid.
  - In the rst cycle: ireq_valid=0, out_valid=0, pc_stall=1.
  - Reset during WAIT/DROP abandons the request; the bus is reset by the same rst.
- Bus rule: once ireq_valid=1, ireq_valid and ireq_addr stay stable until the cycle iresp_ok=1. At most one request is outstanding.
- Advance: pc_stall=0 and pc_next=pc+4 (64-bit wrap) exactly in cycles where an instruction is pushed with no redirect. Otherwise pc_stall=1, except on redirect.
- Redirect, any state:
  - pc_next=redirect_pc, pc_stall=0.
  - count<=0; a same-cycle pop or push is ignored.
  - Next state: DROP if a request is outstanding and iresp_ok=0 this cycle; otherwise IDLE.
  - An iresp_ok arriving in the redirect cycle is discarded.
- IDLE:
  - If count<2 and pc[1:0]==0: ireq_valid=1, ireq_addr=pc.
    - iresp_ok=1: push {pc, iresp_data, 0} and advance; stay IDLE.
    - iresp_ok=0: addr_q<=pc, go to WAIT.
  - If count<2 and pc[1:0]!=0: push {pc, 0, misalign=1}, no bus request, go to HALT.
  - If count==2: no request.
- WAIT: ireq_valid=1, ireq_addr=addr_q. On iresp_ok: push {addr_q, iresp_data, 0}, advance, go to IDLE.
- DROP: ireq_valid=1, ireq_addr=addr_q. On iresp_ok: discard, go to IDLE. A redirect in DROP updates the PC and stays in DROP unless iresp_ok is also high.
- HALT: no requests, pc_stall=1, until redirect.
- Queue:
  - out_valid = (count!=0); out_* reflect the head.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Issue only when count<2; this guarantees a push never finds the queue full (count≤1 in WAIT).
  - FIFO order is preserved.
- Throughput: 1 instruction per cycle with zero-latency responses and out_ready=1.

Test Plan:
- Reset, then pc=0x8000_0000, iresp_ok tied 1, out_ready=1, data=0x13 → ireq_addr=0x8000_0000 in cycle 0, pc_next=0x8000_0004, pc_stall=0; next cycle out_valid=1, out_pc=0x8000_0000, out_instr=0x13; one instruction per cycle thereafter.
- Response latency 3 cycles → ireq_addr stable for 3 cycles, pc_stall=1 throughout; advance only in the iresp_ok cycle.
- out_ready=0, back-to-back responses → two entries queued, ireq_valid=0 with count=2; raise out_ready → entries drain in order, fetch resumes.
- redirect to 0x8000_0100 in WAIT of 0x8000_0008 with response two cycles later → queue empties; ireq_addr stays 0x8000_0008 until iresp_ok; that data is never output; next request is 0x8000_0100.
- redirect in the same cycle as iresp_ok → data dropped, no DROP state, next request at redirect_pc.
- pc=0x8000_0002 → no bus request, output entry with out_misalign=1, out_instr=0; pc_stall=1 until redirect.
